// File: rtl/hdcpu_int_ctrl.sv
// Vectored, prioritised, maskable interrupt controller for the HD-CPU control unit; request registered, edge-to-pending = 3 T3 falls.
// Nested preemption is enabled by defining HDCPU_INT_NEST_EN; otherwise one channel in service at a time.
module hdcpu_int_ctrl #(
  parameter int                N_IRQ      = 4,
  parameter int                VEC_W      = 8,
  parameter logic [VEC_W-1:0]  VEC_BASE   = 8'hE0,
  parameter int                VEC_STRIDE = 4,
  parameter logic [N_IRQ-1:0]  MASK_RST   = '0
) (
  input  logic              T3,
  input  logic              CLR,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              boundary,
  input  logic              int_ack,
  input  logic              iret_done,
  input  logic              ei_set,
  input  logic              ei_clr,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_wdata,
  output logic              int_req,
  output logic [VEC_W-1:0]  int_vec,
  output logic [2:0]        int_id,
  output logic              ei,
  output logic [N_IRQ-1:0]  pending,
  output logic [N_IRQ-1:0]  in_service,
  output logic [N_IRQ-1:0]  mask
);

  localparam logic [N_IRQ-1:0] ONE = {{(N_IRQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ENTRY
  } state_t;

  state_t state_q, state_d;

  logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q, rise;
  logic [N_IRQ-1:0] pending_q, in_service_q, mask_q;
  logic             ei_q;
  logic [2:0]       id_q;
  logic [VEC_W-1:0] vec_q;

  logic [N_IRQ-1:0] elig, id_oh, is_oh, ack_clr;
  logic             win_vld, prio_ok, id_masked;
  logic [2:0]       win_id;
  logic [VEC_W-1:0] win_vec;
  logic             load, ack_take;

  // Two-flop synchroniser followed by an edge register per channel
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    elig    = pending_q & ~mask_q;
    win_vld = |elig;
    win_id  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) win_id = 3'(i);
    end
    win_vec = VEC_W'(32'(VEC_BASE) + 32'(win_id) * 32'(VEC_STRIDE));
  end

  // Lowest set bit of in_service is the highest-priority active ISR
  assign is_oh = in_service_q & (~in_service_q + ONE);

`ifdef HDCPU_INT_NEST_EN
  logic [N_IRQ-1:0] win_oh;
  assign win_oh  = elig & (~elig + ONE);
  assign prio_ok = (in_service_q == '0) || (win_oh < is_oh);
`else
  assign prio_ok = (in_service_q == '0);
`endif

  assign id_oh     = ONE << id_q;
  assign id_masked = |(mask_q & id_oh);

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    ack_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (boundary && ei_q && win_vld && prio_ok) begin
          state_d = S_REQ;
          load    = 1'b1;
        end
      end
      S_REQ: begin
        // An ack in the same cycle as a withdrawal cause means entry has already begun
        if (int_ack) begin
          state_d  = S_ENTRY;
          ack_take = 1'b1;
        end else if (id_masked || ei_clr) begin
          state_d = S_IDLE;
        end
      end
      S_ENTRY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ack_clr = ack_take ? id_oh : '0;

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        id_q  <= win_id;
        vec_q <= win_vec;
      end
    end
  end

  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= MASK_RST;
      ei_q         <= 1'b1;
    end else begin
      // A fresh edge on the acked channel re-arms it in the same cycle
      pending_q    <= (pending_q & ~ack_clr) | rise;
      in_service_q <= (in_service_q & ~(iret_done ? is_oh : '0)) | ack_clr;
      if (mask_we) mask_q <= mask_wdata;
      if (ack_take)                ei_q <= 1'b0;
      else if (ei_clr)             ei_q <= 1'b0;
      else if (ei_set || iret_done) ei_q <= 1'b1;
    end
  end

  assign int_req    = (state_q == S_REQ);
  assign int_vec    = vec_q;
  assign int_id     = id_q;
  assign ei         = ei_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_hdcpu_int_ctrl.sv
// Directed bench for hdcpu_int_ctrl: inputs driven on T3 rising edges, outputs sampled there too.
module tb_hdcpu_int_ctrl;

  logic       T3 = 1'b1;
  logic       CLR = 1'b0;
  logic [3:0] irq_in = '0;
  logic       boundary = 1'b0;
  logic       int_ack = 1'b0;
  logic       iret_done = 1'b0;
  logic       ei_set = 1'b0;
  logic       ei_clr = 1'b0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       int_req;
  logic [7:0] int_vec;
  logic [2:0] int_id;
  logic       ei;
  logic [3:0] pending;
  logic [3:0] in_service;
  logic [3:0] mask;

  int n_chk = 0;
  int n_pass = 0;

  hdcpu_int_ctrl dut (
    .T3(T3), .CLR(CLR), .irq_in(irq_in), .boundary(boundary), .int_ack(int_ack),
    .iret_done(iret_done), .ei_set(ei_set), .ei_clr(ei_clr), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .int_req(int_req), .int_vec(int_vec), .int_id(int_id),
    .ei(ei), .pending(pending), .in_service(in_service), .mask(mask)
  );

  always #5 T3 = ~T3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge T3);
  endtask

  task automatic fire(input logic [3:0] b);
    irq_in = b;
    @(posedge T3);
    irq_in = '0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    step(1);
    int_ack = 1'b0;
  endtask

  task automatic pulse_iret();
    iret_done = 1'b1;
    step(1);
    iret_done = 1'b0;
  endtask

  initial begin
    step(2);
    chk("rst_req", int_req, 0);
    chk("rst_vec", int_vec, 0);
    chk("rst_id", int_id, 0);
    chk("rst_ei", ei, 1);
    chk("rst_pend", pending, 0);
    chk("rst_insvc", in_service, 0);
    chk("rst_mask", mask, 0);
    CLR = 1'b1;
    boundary = 1'b1;
    step(1);

    // 1: single edge on channel 2
    fire(4'b0100);
    step(1);
    chk("t1_pend_e2", pending, 4'b0000);
    step(1);
    chk("t1_pend_e3", pending, 4'b0100);
    chk("t1_req_e3", int_req, 0);
    step(1);
    chk("t1_req", int_req, 1);
    chk("t1_id", int_id, 2);
    chk("t1_vec", int_vec, 8'hE8);
    pulse_ack();
    chk("t1_ack_pend", pending, 0);
    chk("t1_ack_insvc", in_service, 4'b0100);
    chk("t1_ack_ei", ei, 0);
    chk("t1_ack_req", int_req, 0);
    step(1);
    pulse_iret();
    chk("t1_iret_insvc", in_service, 0);
    chk("t1_iret_ei", ei, 1);

    // 2: channels 3 and 1 together
    fire(4'b1010);
    step(2);
    chk("t2_pend", pending, 4'b1010);
    step(1);
    chk("t2_req", int_req, 1);
    chk("t2_id", int_id, 1);
    chk("t2_vec", int_vec, 8'hE4);
    pulse_ack();
    chk("t2_ack_pend", pending, 4'b1000);
    chk("t2_ack_insvc", in_service, 4'b0010);
    chk("t2_ack_ei", ei, 0);
    chk("t2_entry_vec", int_vec, 8'hE4);
    step(1);
    chk("t2_noreq_ei0", int_req, 0);
    pulse_iret();
    chk("t2_iret_ei", ei, 1);
    chk("t2_iret_insvc", in_service, 0);
    step(1);
    chk("t2_req3", int_req, 1);
    chk("t2_id3", int_id, 3);
    chk("t2_vec3", int_vec, 8'hEC);
    pulse_ack();
    chk("t2_insvc3", in_service, 4'b1000);
    step(1);
    pulse_iret();

    // 3: withdrawal by masking while in REQ
    fire(4'b0100);
    step(3);
    chk("t3_req", int_req, 1);
    mask_we = 1'b1;
    mask_wdata = 4'b0100;
    step(1);
    mask_we = 1'b0;
    step(1);
    chk("t3_withdrawn", int_req, 0);
    chk("t3_pend", pending, 4'b0100);
    chk("t3_mask", mask, 4'b0100);
    pulse_ack();
    chk("t3_ack_ign_insvc", in_service, 0);
    chk("t3_ack_ign_pend", pending, 4'b0100);
    chk("t3_ack_ign_ei", ei, 1);
    mask_we = 1'b1;
    mask_wdata = 4'b0000;
    step(1);
    mask_we = 1'b0;
    step(1);
    chk("t3_rereq", int_req, 1);
    chk("t3_reid", int_id, 2);

    // 4: channel 0 arrives while channel 2 is in service with EI re-enabled
    pulse_ack();
    chk("t4_insvc2", in_service, 4'b0100);
    step(1);
    ei_set = 1'b1;
    step(1);
    ei_set = 1'b0;
    chk("t4_ei", ei, 1);
    fire(4'b0001);
    step(2);
    chk("t4_pend", pending, 4'b0001);
    step(1);
`ifdef HDCPU_INT_NEST_EN
    chk("t4_nest_req", int_req, 1);
    chk("t4_nest_id", int_id, 0);
    chk("t4_nest_vec", int_vec, 8'hE0);
    pulse_ack();
    chk("t4_nest_insvc", in_service, 4'b0101);
    step(1);
    pulse_iret();
    chk("t4_iret1", in_service, 4'b0100);
    pulse_iret();
    chk("t4_iret2", in_service, 0);
`else
    chk("t4_block_req", int_req, 0);
    step(1);
    chk("t4_block_req2", int_req, 0);
    pulse_iret();
    chk("t4_iret_insvc", in_service, 0);
    step(1);
    chk("t4_late_req", int_req, 1);
    chk("t4_late_id", int_id, 0);
    pulse_ack();
    chk("t4_late_insvc", in_service, 4'b0001);
    step(1);
    pulse_iret();
`endif

    // 5: asynchronous reset during REQ
    mask_we = 1'b1;
    mask_wdata = 4'b1000;
    step(1);
    mask_we = 1'b0;
    fire(4'b0010);
    step(3);
    chk("t5_req", int_req, 1);
    chk("t5_mask", mask, 4'b1000);
    #2 CLR = 1'b0;
    #1;
    chk("t5_rst_req", int_req, 0);
    chk("t5_rst_vec", int_vec, 0);
    chk("t5_rst_id", int_id, 0);
    chk("t5_rst_ei", ei, 1);
    chk("t5_rst_pend", pending, 0);
    chk("t5_rst_insvc", in_service, 0);
    chk("t5_rst_mask", mask, 0);
    step(1);
    CLR = 1'b1;
    step(1);

    // 6: EI and DI together, DI wins
    boundary = 1'b0;
    ei_clr = 1'b1;
    ei_set = 1'b1;
    step(1);
    ei_clr = 1'b0;
    ei_set = 1'b0;
    chk("t6_ei", ei, 0);
    fire(4'b0001);
    step(2);
    chk("t6_pend", pending, 4'b0001);
    boundary = 1'b1;
    step(2);
    chk("t6_noreq", int_req, 0);
    ei_set = 1'b1;
    step(1);
    ei_set = 1'b0;
    chk("t6_ei_on", ei, 1);
    step(1);
    chk("t6_req", int_req, 1);
    chk("t6_id", int_id, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
